reg_write_arbiter: RTL

- Shares the write port of one CE/PRE-controlled WIDTH-bit register (positive-edge clock, async preset, clock enable) among NREQ requesters.
- Picks one requester round-robin and drives that register's CE, D and PRE for exactly one cycle, then enforces a GAP-cycle settle window before the next access.
- Sits between requesting blocks and the shared register. The register itself stays external.

---
 rtl/reg_write_arbiter_pkg.sv | 22 ++
 rtl/reg_write_arbiter_rr_pick.sv | 34 +++
 rtl/reg_write_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the round-robin write-port arbiter: state encodings,
// parameter defaults and statistics counter widths.
package reg_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_PRESET = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 4;
    localparam int GAP_DEF   = 2;

    // Settle counter must hold GAP-1 for the largest supported GAP (15).
    localparam int GAP_W     = 4;

    localparam int WR_CNT_W  = 16;
    localparam int PRE_CNT_W = 8;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit at or above ptr,
// wrapping from NREQ-1 back to 0.
module rr_pick
    import reg_write_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] idx,
    output logic            valid
);

    // Scan from the farthest offset down so the closest-to-ptr hit wins last.
    always_comb begin
        int pos;
        pos   = 0;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = (int'(ptr) + k) % NREQ;
            if (req[pos]) begin
                gnt      = '0;
                gnt[pos] = 1'b1;
                idx      = IDXW'(pos);
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the CE/D/PRE write port of one shared register.
// Optional statistics outputs WR_CNT/PRE_CNT are enabled by REGARB_STATS_EN.
//
// state     | meaning
// ST_IDLE   | waiting; PRE_REQ wins over REQ, otherwise round-robin pick
// ST_WRITE  | CE, GNT and D driven for exactly this cycle
// ST_PRESET | PRE driven for exactly this cycle
// ST_SETTLE | GAP-cycle quiet window, requests held off
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int GAP   = GAP_DEF
) (
    input  logic                  C,
    input  logic                  CLR_N,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*WIDTH-1:0] D_IN,
    input  logic                  PRE_REQ,
    output logic [NREQ-1:0]       GNT,
    output logic                  CE,
    output logic [WIDTH-1:0]      D,
    output logic                  PRE
`ifdef REGARB_STATS_EN
    ,
    output logic [WR_CNT_W-1:0]   WR_CNT,
    output logic [PRE_CNT_W-1:0]  PRE_CNT
`endif
);

    localparam int IDXW = $clog2(NREQ);

    state_t           state;
    logic [IDXW-1:0]  ptr;
    logic [GAP_W-1:0] gap_cnt;

    logic [NREQ-1:0]  pick_gnt;
    logic [IDXW-1:0]  pick_idx;
    logic             pick_valid;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req   (REQ),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            gap_cnt <= '0;
            GNT     <= '0;
            CE      <= 1'b0;
            PRE     <= 1'b0;
            D       <= '0;
        end else begin
            // Pulses last one cycle; D deliberately keeps its last value.
            GNT <= '0;
            CE  <= 1'b0;
            PRE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (PRE_REQ) begin
                        state <= ST_PRESET;
                        PRE   <= 1'b1;
                    end else if (pick_valid) begin
                        state <= ST_WRITE;
                        GNT   <= pick_gnt;
                        CE    <= 1'b1;
                        D     <= D_IN[pick_idx*WIDTH +: WIDTH];
                        ptr   <= (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
                    end
                end
                ST_WRITE, ST_PRESET: begin
                    if (GAP > 0) begin
                        state   <= ST_SETTLE;
                        gap_cnt <= GAP_W'(GAP - 1);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef REGARB_STATS_EN
    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            WR_CNT  <= '0;
            PRE_CNT <= '0;
        end else begin
            if (state == ST_WRITE && WR_CNT != '1) begin
                WR_CNT <= WR_CNT + 1'b1;
            end
            if (state == ST_PRESET && PRE_CNT != '1) begin
                PRE_CNT <= PRE_CNT + 1'b1;
            end
        end
    end
`endif

endmodule
